// File: rtl/alu_exec_seq.sv
// Execute-stage ALU with a valid/ready request port and a valid/ready result port.
// Logic, add and compare ops finish in one cycle. Shifts and rotates move one bit
// per cycle, so a long shift holds in_ready low and stalls the pipeline.
module alu_exec_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Op,
    input  logic             Cin,
    input  logic             invA,
    input  logic             invB,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Ofl,
    output logic             Z,
    output logic             err
);

    localparam logic [4:0] OP_ROL    = 5'b00000;
    localparam logic [4:0] OP_SLL    = 5'b00001;
    localparam logic [4:0] OP_SRL    = 5'b00011;
    localparam logic [4:0] OP_ADD    = 5'b00100;
    localparam logic [4:0] OP_XOR    = 5'b00110;
    localparam logic [4:0] OP_AND    = 5'b00111;
    localparam logic [4:0] OP_ROR    = 5'b01000;
    localparam logic [4:0] OP_BTR    = 5'b01001;
    localparam logic [4:0] OP_EQ     = 5'b01010;
    localparam logic [4:0] OP_LT     = 5'b01011;
    localparam logic [4:0] OP_LE     = 5'b01100;
    localparam logic [4:0] OP_CARRY  = 5'b01101;
    localparam logic [4:0] OP_NE     = 5'b01110;
    localparam logic [4:0] OP_GE     = 5'b01111;
    localparam logic [4:0] OP_CONCAT = 5'b10000;

    localparam logic [WIDTH-1:0]   ZERO_W = {WIDTH{1'b0}};
    localparam logic [SHAMT_W-1:0] ONE_S  = {{(SHAMT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One 1-bit step of the shift/rotate selected by op.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] val,
                                                    input logic [4:0] op);
        logic [WIDTH-1:0] r;
        case (op)
            OP_ROL:  r = {val[WIDTH-2:0], val[WIDTH-1]};
            OP_SLL:  r = {val[WIDTH-2:0], 1'b0};
            OP_ROR:  r = {val[0], val[WIDTH-1:1]};
            OP_SRL:  r = {1'b0, val[WIDTH-1:1]};
            default: r = val;
        endcase
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [4:0]         op_q, op_d;
    logic               ofl_q, ofl_d;
    logic               z_q, z_d;
    logic               err_q, err_d;
    logic               rdy_en_q;

    logic [WIDTH-1:0]   aa_s, bb_s, s_s, alu_res_s, btr_s, step_s;
    logic [WIDTH:0]     sum_s;
    logic               co_s, v_s, lt_s, eq_s, alu_ofl_s, alu_err_s, is_shift_s, accept_s;
    logic [SHAMT_W-1:0] shamt_s;

    // Combinational datapath evaluated on the incoming request.
    always_comb begin
        aa_s      = invA ? ~A : A;
        bb_s      = invB ? ~B : B;
        sum_s     = {1'b0, aa_s} + {1'b0, bb_s} + {{WIDTH{1'b0}}, Cin};
        co_s      = sum_s[WIDTH];
        s_s       = sum_s[WIDTH-1:0];
        v_s       = (aa_s[WIDTH-1] == bb_s[WIDTH-1]) && (s_s[WIDTH-1] != aa_s[WIDTH-1]);
        lt_s      = sign ? (s_s[WIDTH-1] ^ v_s) : ~co_s;
        eq_s      = (A == B);
        shamt_s   = B[SHAMT_W-1:0];
        btr_s     = ZERO_W;
        for (int i = 0; i < WIDTH; i++) begin
            btr_s[i] = A[WIDTH-1-i];
        end
        alu_ofl_s  = 1'b0;
        alu_err_s  = 1'b0;
        is_shift_s = 1'b0;
        case (Op)
            OP_ADD: begin
                alu_res_s = s_s;
                alu_ofl_s = sign ? v_s : co_s;
            end
            OP_XOR:    alu_res_s = aa_s ^ bb_s;
            OP_AND:    alu_res_s = aa_s & bb_s;
            OP_BTR:    alu_res_s = btr_s;
            OP_EQ:     alu_res_s = {{(WIDTH-1){1'b0}}, eq_s};
            OP_NE:     alu_res_s = {{(WIDTH-1){1'b0}}, ~eq_s};
            OP_LT:     alu_res_s = {{(WIDTH-1){1'b0}}, lt_s};
            OP_LE:     alu_res_s = {{(WIDTH-1){1'b0}}, lt_s | eq_s};
            OP_GE:     alu_res_s = {{(WIDTH-1){1'b0}}, ~lt_s};
            OP_CARRY:  alu_res_s = {{(WIDTH-1){1'b0}}, co_s};
            OP_CONCAT: alu_res_s = {A[WIDTH/2-1:0], B[WIDTH/2-1:0]};
            OP_ROL, OP_SLL, OP_ROR, OP_SRL: begin
                // Shift by zero completes immediately with A unchanged.
                alu_res_s  = A;
                is_shift_s = 1'b1;
            end
            default: begin
                alu_res_s = ZERO_W;
                alu_err_s = 1'b1;
            end
        endcase
    end

    // Output/handshake decode from the current state.
    always_comb begin
        if (state_q == ST_IDLE) begin
            in_ready = rdy_en_q;
        end else if (state_q == ST_DONE) begin
            in_ready = rdy_en_q & out_ready;
        end else begin
            in_ready = 1'b0;
        end
        out_valid = (state_q == ST_DONE);
        accept_s  = in_valid & in_ready;
        Out       = res_q;
        Ofl       = ofl_q;
        Z         = z_q;
        err       = err_q;
    end

    // Next-state and next-result computation.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ofl_d   = ofl_q;
        z_d     = z_q;
        err_d   = err_q;
        step_s  = shift_step(res_q, op_q);
        if (accept_s) begin
            op_d  = Op;
            ofl_d = alu_ofl_s;
            err_d = alu_err_s;
            if (is_shift_s && (shamt_s != {SHAMT_W{1'b0}})) begin
                state_d = ST_SHIFT;
                res_d   = A;
                cnt_d   = shamt_s;
                z_d     = 1'b0;
            end else begin
                state_d = ST_DONE;
                res_d   = alu_res_s;
                cnt_d   = {SHAMT_W{1'b0}};
                z_d     = (alu_res_s == ZERO_W);
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_SHIFT: begin
                    res_d = step_s;
                    cnt_d = cnt_q - ONE_S;
                    z_d   = (step_s == ZERO_W);
                    if (cnt_q == ONE_S) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and result registers; reset drops any in-flight or pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            res_q    <= {WIDTH{1'b0}};
            cnt_q    <= {SHAMT_W{1'b0}};
            op_q     <= 5'b00000;
            ofl_q    <= 1'b0;
            z_q      <= 1'b0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            ofl_q    <= ofl_d;
            z_q      <= z_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed, table-driven bench for alu_exec_seq with hand-computed expectations.
module tb_alu_exec_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] A, B;
    logic [4:0]  Op;
    logic        Cin, invA, invB, sign;
    logic        out_valid, out_ready;
    logic [15:0] Out;
    logic        Ofl, Z, err;

    int total = 0;
    int bad   = 0;

    alu_exec_seq #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Op(Op), .Cin(Cin), .invA(invA), .invB(invB), .sign(sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .Out(Out), .Ofl(Ofl), .Z(Z), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        ia;
        logic        ib;
        logic        sg;
        logic [15:0] e_out;
        logic        e_ofl;
        logic        e_z;
        logic        e_err;
        int          e_lat;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Op = v.op; A = v.a; B = v.b; Cin = v.cin; invA = v.ia; invB = v.ib; sign = v.sg;
        in_valid = 1'b1;
    endtask

    function automatic vec_t mk(input string nm, input logic [4:0] op, input logic [15:0] a,
                                input logic [15:0] b, input logic cin, input logic ia,
                                input logic ib, input logic sg, input logic [15:0] eo,
                                input logic eofl, input logic ez, input logic eerr,
                                input int lat);
        vec_t v;
        v.name = nm; v.op = op; v.a = a; v.b = b; v.cin = cin; v.ia = ia; v.ib = ib;
        v.sg = sg; v.e_out = eo; v.e_ofl = eofl; v.e_z = ez; v.e_err = eerr; v.e_lat = lat;
        return v;
    endfunction

    initial begin
        int lat;
        //              name        op        A         B        cin ia ib sg  Out      Ofl  Z    err  lat
        vecs[0]  = mk("add_s_ovf", 5'b00100, 16'h7FFF, 16'h0001, 0, 0, 0, 1, 16'h8000, 1'b1, 1'b0, 1'b0, 1);
        vecs[1]  = mk("add_u",     5'b00100, 16'h7FFF, 16'h0001, 0, 0, 0, 0, 16'h8000, 1'b0, 1'b0, 1'b0, 1);
        vecs[2]  = mk("sub",       5'b00100, 16'h0003, 16'h0001, 1, 1, 0, 0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1);
        vecs[3]  = mk("add_carry", 5'b00100, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 16'h0000, 1'b1, 1'b1, 1'b0, 1);
        vecs[4]  = mk("lt_s",      5'b01011, 16'hFFFF, 16'h0001, 1, 0, 1, 1, 16'h0001, 1'b0, 1'b0, 1'b0, 1);
        vecs[5]  = mk("le_eq",     5'b01100, 16'h0005, 16'h0005, 1, 0, 1, 1, 16'h0001, 1'b0, 1'b0, 1'b0, 1);
        vecs[6]  = mk("ge_u",      5'b01111, 16'h0003, 16'h0005, 1, 0, 1, 0, 16'h0000, 1'b0, 1'b1, 1'b0, 1);
        vecs[7]  = mk("xor",       5'b00110, 16'hF0F0, 16'hFF00, 0, 0, 0, 0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1);
        vecs[8]  = mk("and_invb",  5'b00111, 16'hF0F0, 16'hFF00, 0, 0, 1, 0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1);
        vecs[9]  = mk("btr",       5'b01001, 16'h1234, 16'h0000, 0, 0, 0, 0, 16'h2C48, 1'b0, 1'b0, 1'b0, 1);
        vecs[10] = mk("eq",        5'b01010, 16'h1234, 16'h1234, 0, 0, 0, 0, 16'h0001, 1'b0, 1'b0, 1'b0, 1);
        vecs[11] = mk("ne",        5'b01110, 16'h1234, 16'h1234, 0, 0, 0, 0, 16'h0000, 1'b0, 1'b1, 1'b0, 1);
        vecs[12] = mk("carry",     5'b01101, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 16'h0001, 1'b0, 1'b0, 1'b0, 1);
        vecs[13] = mk("concat",    5'b10000, 16'h12AB, 16'h34CD, 0, 0, 0, 0, 16'hABCD, 1'b0, 1'b0, 1'b0, 1);
        vecs[14] = mk("ror4",      5'b01000, 16'h0001, 16'h0004, 0, 0, 0, 0, 16'h1000, 1'b0, 1'b0, 1'b0, 5);
        vecs[15] = mk("sll0",      5'b00001, 16'h1234, 16'h0000, 0, 0, 0, 0, 16'h1234, 1'b0, 1'b0, 1'b0, 1);
        vecs[16] = mk("rol1",      5'b00000, 16'h8001, 16'h0001, 0, 0, 0, 0, 16'h0003, 1'b0, 1'b0, 1'b0, 2);
        vecs[17] = mk("sll8",      5'b00001, 16'h00FF, 16'h0008, 0, 0, 0, 0, 16'hFF00, 1'b0, 1'b0, 1'b0, 9);
        vecs[18] = mk("srl15",     5'b00011, 16'h8000, 16'h000F, 0, 0, 0, 0, 16'h0001, 1'b0, 1'b0, 1'b0, 16);
        vecs[19] = mk("bad_op",    5'b10101, 16'h1234, 16'h5678, 0, 0, 0, 0, 16'h0000, 1'b0, 1'b1, 1'b1, 1);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = 16'h0000; B = 16'h0000; Op = 5'b00000; Cin = 1'b0; invA = 1'b0; invB = 1'b0; sign = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", {16'd0, Out}, 32'd0);
        check("rst_flags", {29'd0, Ofl, Z, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Table of single operations.
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i]);
            lat = 0;
            do begin
                @(negedge clk);
                in_valid = 1'b0;
                lat++;
                if (!out_valid) check({vecs[i].name, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
            end while (!out_valid && lat < 40);
            check({vecs[i].name, "_lat"}, lat, vecs[i].e_lat);
            check({vecs[i].name, "_out"}, {16'd0, Out}, {16'd0, vecs[i].e_out});
            check({vecs[i].name, "_ofl"}, {31'd0, Ofl}, {31'd0, vecs[i].e_ofl});
            check({vecs[i].name, "_z"}, {31'd0, Z}, {31'd0, vecs[i].e_z});
            check({vecs[i].name, "_err"}, {31'd0, err}, {31'd0, vecs[i].e_err});
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check({vecs[i].name, "_drain"}, {30'd0, out_valid, in_ready}, 32'd1);
        end

        // Hold result under back-pressure, then back-to-back accept from DONE.
        drive(mk("h", 5'b00100, 16'h0001, 16'h0001, 0, 0, 0, 0, 16'h0, 0, 0, 0, 1));
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_out", {16'd0, Out}, 32'h0002);
        end
        drive(mk("x", 5'b00110, 16'hFFFF, 16'h00FF, 0, 0, 0, 0, 16'h0, 0, 0, 0, 1));
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_out", {16'd0, Out}, 32'hFF00);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a 15-bit shift.
        drive(vecs[18]);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out", {16'd0, Out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_idle_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_idle_valid", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
